frame_scheduler: RTL and testbench

Per-frame sequencer for the game's shared VGA plotter. Divides the 50 MHz system clock into a frame tick, applies a frame-skip ratio to decide which frames run a game update, and on each update frame serialises the drawing clients' access to the single plotter: an erase pass, a one-cycle game-state update pulse, then a draw pass. It sits between the frame timing logic and the sprite/obstacle/ground/score drawing clients.

---
 rtl/frame_scheduler.sv | 176 +++++++++++++++++
 tb/tb_frame_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - frame tick, frame-skip and erase/update/draw plotter sequencing
// Erase pass is built only when FRAME_SCHED_ERASE_EN is defined.
module frame_scheduler #(
   parameter int FRAME_DIV = 833333,
   parameter int CNT_W     = 20,
   parameter int CLIENTS   = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [3:0]         skip_count,
   input  logic [CLIENTS-1:0] req,
   input  logic               done,
   output logic               frame_tick,
   output logic               update_tick,
   output logic [CLIENTS-1:0] grant,
   output logic               erase,
   output logic               busy,
   output logic               frame_overrun
);
   localparam int IDX_W = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(FRAME_DIV - 1);
   localparam logic [IDX_W-1:0] LAST   = IDX_W'(CLIENTS - 1);

   typedef enum logic [2:0] {IDLE, E_SCAN, E_GRANT, UPDATE, D_SCAN, D_GRANT} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         skip_q, skip_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CLIENTS-1:0] grant_q, grant_d;
   logic               frame_tick_q, frame_tick_d;
   logic               update_tick_q, update_tick_d;
   logic               erase_q, erase_d;
   logic               busy_q, busy_d;
   logic               overrun_q, overrun_d;
   logic               due;

   always_comb begin
      cnt_d        = cnt_q;
      frame_tick_d = 1'b0;
      if (enable) begin
         if (cnt_q == '0) begin
            cnt_d        = RELOAD;
            frame_tick_d = 1'b1;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end

      due    = 1'b0;
      skip_d = skip_q;
      if (frame_tick_q) begin
         if (skip_q == 4'd0) begin
            skip_d = skip_count;
            due    = 1'b1;
         end else begin
            skip_d = skip_q - 4'd1;
         end
      end

      state_d       = state_q;
      idx_d         = idx_q;
      grant_d       = grant_q;
      erase_d       = 1'b0;
      overrun_d     = overrun_q;
      update_tick_d = (state_q == UPDATE);

      // A due frame that finds a sequence in flight is dropped, not restarted.
      if (due && (state_q != IDLE))
         overrun_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (due) begin
               idx_d = '0;
`ifdef FRAME_SCHED_ERASE_EN
               state_d = E_SCAN;
`else
               state_d = UPDATE;
`endif
            end
         end
`ifdef FRAME_SCHED_ERASE_EN
         E_SCAN: begin
            if (req[idx_q]) begin
               state_d = E_GRANT;
               grant_d = CLIENTS'(1) << idx_q;
               erase_d = 1'b1;
            end else if (idx_q == LAST) begin
               state_d = UPDATE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         E_GRANT: begin
            erase_d = 1'b1;
            if (done) begin
               grant_d = '0;
               erase_d = 1'b0;
               if (idx_q == LAST) begin
                  state_d = UPDATE;
               end else begin
                  state_d = E_SCAN;
                  idx_d   = idx_q + IDX_W'(1);
               end
            end
         end
`endif
         UPDATE: begin
            state_d = D_SCAN;
            idx_d   = '0;
         end
         D_SCAN: begin
            if (req[idx_q]) begin
               state_d = D_GRANT;
               grant_d = CLIENTS'(1) << idx_q;
            end else if (idx_q == LAST) begin
               state_d = IDLE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         D_GRANT: begin
            if (done) begin
               grant_d = '0;
               if (idx_q == LAST) begin
                  state_d = IDLE;
               end else begin
                  state_d = D_SCAN;
                  idx_d   = idx_q + IDX_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         skip_q        <= '0;
         idx_q         <= '0;
         grant_q       <= '0;
         frame_tick_q  <= 1'b0;
         update_tick_q <= 1'b0;
         erase_q       <= 1'b0;
         busy_q        <= 1'b0;
         overrun_q     <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         skip_q        <= skip_d;
         idx_q         <= idx_d;
         grant_q       <= grant_d;
         frame_tick_q  <= frame_tick_d;
         update_tick_q <= update_tick_d;
         erase_q       <= erase_d;
         busy_q        <= busy_d;
         overrun_q     <= overrun_d;
      end
   end

   assign frame_tick    = frame_tick_q;
   assign update_tick   = update_tick_q;
   assign grant         = grant_q;
   assign erase         = erase_q;
   assign busy          = busy_q;
   assign frame_overrun = overrun_q;
endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - scoreboard bench for frame_scheduler (FRAME_DIV 10, 4 clients)
module tb_frame_scheduler;
   typedef struct {
      byte        kind;
      logic [3:0] val;
      logic       er;
      int         cyc;
   } ev_t;

`ifdef FRAME_SCHED_ERASE_EN
   localparam int   UO = 6;
   localparam logic ER = 1'b1;
`else
   localparam int   UO = 2;
   localparam logic ER = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic [3:0] skip_count = 4'd0;
   logic [3:0] req = 4'd0;
   logic       done = 1'b0;
   logic       frame_tick, update_tick, erase, busy, frame_overrun;
   logic [3:0] grant;

   ev_t        exp_q[$];
   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         base = 0;
   int         resp_lat = 0;
   int         gcnt = 0;
   logic [3:0] prev_g = 4'd0;
   logic       mon_en = 1'b0;

   frame_scheduler #(.FRAME_DIV(10), .CNT_W(4), .CLIENTS(4)) dut (
      .clk(clk), .reset(reset), .enable(enable), .skip_count(skip_count),
      .req(req), .done(done), .frame_tick(frame_tick), .update_tick(update_tick),
      .grant(grant), .erase(erase), .busy(busy), .frame_overrun(frame_overrun)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc - base);
      end
   endtask

   task automatic ex(input byte k, input int c, input logic [3:0] v, input logic e);
      ev_t x;
      x.kind = k; x.cyc = c; x.val = v; x.er = e;
      exp_q.push_back(x);
   endtask

   task automatic pop_cmp(input byte k, input int c, input logic [3:0] v, input logic e);
      ev_t x;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL event: got unexpected %c cycle %0d val %b erase %b", k, c, v, e);
      end else begin
         x = exp_q.pop_front();
         if (x.kind != k || x.cyc != c || x.val != v || x.er != e) begin
            errors++;
            $display("FAIL event: got %c cycle %0d val %b erase %b expected %c cycle %0d val %b erase %b",
                     k, c, v, e, x.kind, x.cyc, x.val, x.er);
         end
      end
   endtask

   // Monitor: every observed output event is matched against the scoreboard.
   always @(negedge clk) begin
      if (mon_en) begin
         check("grant_onehot", int'($countones(grant) <= 1), 1);
         if (frame_tick) pop_cmp("T", cyc - base, 4'd0, 1'b0);
         if (update_tick) pop_cmp("U", cyc - base, 4'd0, 1'b0);
         if (grant != 4'd0 && prev_g == 4'd0) pop_cmp("G", cyc - base, grant, erase);
      end
      prev_g = grant;
   end

   // Plotter model: done pulses resp_lat cycles after the first grant cycle.
   always @(negedge clk) begin
      if (grant != 4'd0) gcnt = gcnt + 1;
      else gcnt = 0;
      if (resp_lat > 0) done = (gcnt == resp_lat + 1);
   end

   task automatic start(input logic [3:0] s, input logic [3:0] r);
      skip_count = s;
      req = r;
      base = cyc;
      reset = 1'b0;
      enable = 1'b1;
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic finish_phase(input string name);
      check(name, exp_q.size(), 0);
      exp_q.delete();
      reset = 1'b1;
      enable = 1'b0;
      done = 1'b0;
      req = 4'd0;
      resp_lat = 0;
      run(2);
   endtask

   initial begin
      run(3);
      check("rst_frame_tick", int'(frame_tick), 0);
      check("rst_update_tick", int'(update_tick), 0);
      check("rst_grant", int'(grant), 0);
      check("rst_erase", int'(erase), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_overrun", int'(frame_overrun), 0);
      mon_en = 1'b1;

      // Every frame is an update frame.
      ex("T", 1, 0, 0); ex("U", 1 + UO, 0, 0);
      ex("T", 11, 0, 0); ex("U", 11 + UO, 0, 0);
      ex("T", 21, 0, 0); ex("U", 21 + UO, 0, 0);
      start(4'd0, 4'd0);
      run(29);
      finish_phase("skip0_left");

      // Updates every third frame.
      ex("T", 1, 0, 0); ex("U", 1 + UO, 0, 0); ex("T", 11, 0, 0); ex("T", 21, 0, 0);
      ex("T", 31, 0, 0); ex("U", 31 + UO, 0, 0); ex("T", 41, 0, 0); ex("T", 51, 0, 0);
      ex("T", 61, 0, 0); ex("U", 61 + UO, 0, 0);
      start(4'd2, 4'd0);
      run(69);
      finish_phase("skip2_left");

      // Two requesting clients, plotter takes 3 wait cycles.
`ifdef FRAME_SCHED_ERASE_EN
      ex("T", 1, 0, 0); ex("G", 3, 4'b0001, 1); ex("G", 9, 4'b0100, 1); ex("T", 11, 0, 0);
      ex("U", 15, 0, 0); ex("G", 16, 4'b0001, 0); ex("T", 21, 0, 0); ex("G", 22, 4'b0100, 0);
`else
      ex("T", 1, 0, 0); ex("U", 3, 0, 0); ex("G", 4, 4'b0001, 0); ex("G", 10, 4'b0100, 0);
      ex("T", 11, 0, 0); ex("T", 21, 0, 0);
`endif
      resp_lat = 3;
      start(4'd2, 4'b0101);
      run(29);
      check("jobs_busy_end", int'(busy), 0);
      check("jobs_overrun", int'(frame_overrun), 0);
      finish_phase("jobs_left");

      // Stalled plotter causes a dropped due frame.
`ifdef FRAME_SCHED_ERASE_EN
      ex("T", 1, 0, 0); ex("G", 3, 4'b0001, 1); ex("T", 11, 0, 0); ex("U", 19, 0, 0);
      ex("T", 21, 0, 0); ex("T", 31, 0, 0); ex("U", 37, 0, 0);
`else
      ex("T", 1, 0, 0); ex("U", 3, 0, 0); ex("G", 4, 4'b0001, 0); ex("T", 11, 0, 0);
      ex("T", 21, 0, 0); ex("U", 23, 0, 0); ex("T", 31, 0, 0); ex("U", 33, 0, 0);
`endif
      start(4'd0, 4'b0001);
      run(14);
      check("ovr_flag", int'(frame_overrun), 1);
      check("ovr_grant_held", int'(grant), 1);
      check("ovr_busy", int'(busy), 1);
      req = 4'd0;
      done = 1'b1;
      run(25);
      check("ovr_sticky", int'(frame_overrun), 1);
      finish_phase("ovr_left");
      check("ovr_cleared", int'(frame_overrun), 0);

      // Reset while client 1 owns the plotter.
`ifdef FRAME_SCHED_ERASE_EN
      ex("T", 1, 0, 0); ex("G", 4, 4'b0010, 1);
`else
      ex("T", 1, 0, 0); ex("U", 3, 0, 0); ex("G", 5, 4'b0010, 0);
`endif
      start(4'd0, 4'b0010);
      run(6);
      check("mid_grant", int'(grant), 2);
      reset = 1'b1;
      run(1);
      check("mid_rst_grant", int'(grant), 0);
      check("mid_rst_busy", int'(busy), 0);
      check("mid_rst_erase", int'(erase), 0);
      finish_phase("mid_left");
      ex("T", 1, 0, 0); ex("U", 1 + UO, 0, 0);
      start(4'd0, 4'd0);
      run(9);
      check("post_rst_overrun", int'(frame_overrun), 0);
      finish_phase("post_rst_left");

      // All clients requesting, zero-wait plotter.
`ifdef FRAME_SCHED_ERASE_EN
      ex("T", 1, 0, 0); ex("G", 3, 4'b0001, 1); ex("G", 5, 4'b0010, 1); ex("G", 7, 4'b0100, 1);
      ex("G", 9, 4'b1000, 1); ex("T", 11, 0, 0); ex("U", 11, 0, 0); ex("G", 12, 4'b0001, 0);
`else
      ex("T", 1, 0, 0); ex("U", 3, 0, 0); ex("G", 4, 4'b0001, 0); ex("G", 6, 4'b0010, 0);
      ex("G", 8, 4'b0100, 0); ex("G", 10, 4'b1000, 0); ex("T", 11, 0, 0);
`endif
      done = 1'b1;
      start(4'd1, 4'b1111);
      run(12);
      check("zw_overrun", int'(frame_overrun), 0);
      check("zw_erase_cfg", int'(ER), int'(ER));
      finish_phase("zw_left");

      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
